clock_edit_controller: RTL

Sequences user edits of the clock state storage block. Turns debounced front-panel buttons into the one-hot `cursorPos` field select, single-cycle `up`/`down` step pulses with hold-to-repeat, and a `clearTime` pulse. Owns the run/edit mode state machine, edit timeout and cursor-blink timing. Sits between the button debouncers and ClockStateStorage.

---
 rtl/clock_edit_controller.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/clock_edit_controller.sv
// clock_edit_controller
// Turns debounced front-panel buttons into edit controls for the clock state
// storage: one-hot field select, up/down step pulses with hold-to-repeat, a
// clear pulse, edit-mode timeout and cursor blink timing.
module clock_edit_controller #(
    parameter int unsigned REPEAT_DELAY_CYC = 32'd50_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 32'd10_000_000,
    parameter int unsigned IDLE_TIMEOUT_CYC = 32'd1_000_000_000,
    parameter int unsigned BLINK_HALF_CYC   = 32'd25_000_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       btnMode,
    input  logic       btnClear,
    input  logic       btnUp,
    input  logic       btnDown,
    output logic [2:0] cursorPos,
    output logic       up,
    output logic       down,
    output logic       clearTime,
    output logic       editing,
    output logic       blinkOn
);

    // Mode FSM encoding
    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_EDIT_HR  = 2'd1;
    localparam logic [1:0] MODE_EDIT_MIN = 2'd2;
    localparam logic [1:0] MODE_EDIT_SEC = 2'd3;

    // Key tracker encoding
    localparam logic [1:0] KEY_NONE    = 2'd0;
    localparam logic [1:0] KEY_UP      = 2'd1;
    localparam logic [1:0] KEY_DOWN    = 2'd2;
    localparam logic [1:0] KEY_BLOCKED = 2'd3;

    // Terminal counts: a counter matching its "last" value expires this edge
    localparam logic [31:0] REP_DELAY_LAST = 32'(REPEAT_DELAY_CYC - 32'd1);
    localparam logic [31:0] REP_RATE_LAST  = 32'(REPEAT_RATE_CYC - 32'd1);
    localparam logic [29:0] IDLE_LAST      = 30'(IDLE_TIMEOUT_CYC - 32'd1);
    localparam logic [31:0] BLINK_LAST     = 32'(BLINK_HALF_CYC - 32'd1);

    // One-hot field select for a mode; RUN selects nothing
    function automatic logic [2:0] cursor_of(input logic [1:0] mode);
        logic [2:0] sel;
        case (mode)
            MODE_EDIT_HR:  sel = 3'b100;
            MODE_EDIT_MIN: sel = 3'b010;
            MODE_EDIT_SEC: sel = 3'b001;
            default:       sel = 3'b000;
        endcase
        return sel;
    endfunction

    // State registers
    logic [1:0]  mode_r;
    logic [1:0]  key_r;
    logic        up_prev_r;
    logic        down_prev_r;
    logic [31:0] rep_cnt_r;
    logic        rep_phase_r;   // 0: waiting for first repeat, 1: steady rate
    logic [29:0] idle_cnt_r;
    logic [31:0] blink_cnt_r;
    logic        blink_r;
    logic [2:0]  cursor_r;
    logic        editing_r;
    logic        up_r;
    logic        down_r;
    logic        clear_r;

    // Next-state signals
    logic [1:0]  mode_next_s;
    logic [1:0]  key_next_s;
    logic [31:0] rep_cnt_next_s;
    logic        rep_phase_next_s;
    logic        step_s;
    logic        up_next_s;
    logic        down_next_s;
    logic [29:0] idle_cnt_next_s;
    logic [31:0] blink_cnt_next_s;
    logic        blink_next_s;
    logic        activity_s;
    logic        edit_s;
    logic        up_rise_s;
    logic        down_rise_s;

    assign activity_s  = btnMode | btnClear | btnUp | btnDown;
    assign edit_s      = (mode_r != MODE_RUN);
    assign up_rise_s   = btnUp & ~up_prev_r;
    assign down_rise_s = btnDown & ~down_prev_r;

    // Mode FSM: advance on btnMode, fall back to RUN after the idle timeout
    always_comb begin
        mode_next_s = mode_r;
        if (btnMode) begin
            case (mode_r)
                MODE_RUN:      mode_next_s = MODE_EDIT_HR;
                MODE_EDIT_HR:  mode_next_s = MODE_EDIT_MIN;
                MODE_EDIT_MIN: mode_next_s = MODE_EDIT_SEC;
                MODE_EDIT_SEC: mode_next_s = MODE_RUN;
                default:       mode_next_s = MODE_RUN;
            endcase
        end else if (edit_s && !activity_s && (idle_cnt_r == IDLE_LAST)) begin
            mode_next_s = MODE_RUN;
        end else begin
            mode_next_s = mode_r;
        end
    end

    // Idle counter: cleared by activity, parked at zero in RUN
    always_comb begin
        idle_cnt_next_s = 30'd0;
        if (activity_s || (mode_next_s == MODE_RUN)) begin
            idle_cnt_next_s = 30'd0;
        end else begin
            idle_cnt_next_s = idle_cnt_r + 30'd1;
        end
    end

    // Key tracker: one active direction at a time, conflicts lock out until both keys release
    always_comb begin
        key_next_s = key_r;
        case (key_r)
            KEY_NONE: begin
                if (up_rise_s && down_rise_s) begin
                    key_next_s = KEY_BLOCKED;
                end else if (up_rise_s) begin
                    key_next_s = btnDown ? KEY_BLOCKED : KEY_UP;
                end else if (down_rise_s) begin
                    key_next_s = btnUp ? KEY_BLOCKED : KEY_DOWN;
                end else begin
                    key_next_s = KEY_NONE;
                end
            end
            KEY_UP: begin
                if (btnDown || btnMode) begin
                    key_next_s = KEY_BLOCKED;
                end else if (!btnUp) begin
                    key_next_s = KEY_NONE;
                end else begin
                    key_next_s = KEY_UP;
                end
            end
            KEY_DOWN: begin
                if (btnUp || btnMode) begin
                    key_next_s = KEY_BLOCKED;
                end else if (!btnDown) begin
                    key_next_s = KEY_NONE;
                end else begin
                    key_next_s = KEY_DOWN;
                end
            end
            KEY_BLOCKED: begin
                if (!btnUp && !btnDown) begin
                    key_next_s = KEY_NONE;
                end else begin
                    key_next_s = KEY_BLOCKED;
                end
            end
            default: key_next_s = KEY_BLOCKED;
        endcase
    end

    // Step generation: one step on entry, first repeat after the delay, then at the rate
    always_comb begin
        step_s           = 1'b0;
        rep_cnt_next_s   = 32'd0;
        rep_phase_next_s = 1'b0;
        if (key_next_s != key_r) begin
            step_s           = (key_next_s == KEY_UP) || (key_next_s == KEY_DOWN);
            rep_cnt_next_s   = 32'd0;
            rep_phase_next_s = 1'b0;
        end else if ((key_r == KEY_UP) || (key_r == KEY_DOWN)) begin
            if ((!rep_phase_r && (rep_cnt_r == REP_DELAY_LAST)) ||
                (rep_phase_r && (rep_cnt_r == REP_RATE_LAST))) begin
                step_s           = 1'b1;
                rep_cnt_next_s   = 32'd0;
                rep_phase_next_s = 1'b1;
            end else begin
                rep_cnt_next_s   = rep_cnt_r + 32'd1;
                rep_phase_next_s = rep_phase_r;
            end
        end else begin
            rep_cnt_next_s   = 32'd0;
            rep_phase_next_s = 1'b0;
        end
    end

    // Steps only reach the outputs while a field is being edited
    always_comb begin
        up_next_s   = 1'b0;
        down_next_s = 1'b0;
        if (step_s && edit_s) begin
            up_next_s   = (key_next_s == KEY_UP);
            down_next_s = (key_next_s == KEY_DOWN);
        end else begin
            up_next_s   = 1'b0;
            down_next_s = 1'b0;
        end
    end

    // Blink: solid in RUN, restarted lit on field entry and on every step
    always_comb begin
        blink_next_s     = 1'b1;
        blink_cnt_next_s = 32'd0;
        if (mode_next_s == MODE_RUN) begin
            blink_next_s     = 1'b1;
            blink_cnt_next_s = 32'd0;
        end else if (mode_next_s != mode_r) begin
            blink_next_s     = 1'b1;
            blink_cnt_next_s = 32'd0;
        end else if (up_next_s || down_next_s) begin
            blink_next_s     = 1'b1;
            blink_cnt_next_s = 32'd0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_next_s     = ~blink_r;
            blink_cnt_next_s = 32'd0;
        end else begin
            blink_next_s     = blink_r;
            blink_cnt_next_s = blink_cnt_r + 32'd1;
        end
    end

    // State and output registers; tracker wakes up BLOCKED so a held key never fires
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mode_r      <= MODE_RUN;
            key_r       <= KEY_BLOCKED;
            up_prev_r   <= 1'b0;
            down_prev_r <= 1'b0;
            rep_cnt_r   <= 32'd0;
            rep_phase_r <= 1'b0;
            idle_cnt_r  <= 30'd0;
            blink_cnt_r <= 32'd0;
            blink_r     <= 1'b1;
            cursor_r    <= 3'b000;
            editing_r   <= 1'b0;
            up_r        <= 1'b0;
            down_r      <= 1'b0;
            clear_r     <= 1'b0;
        end else begin
            mode_r      <= mode_next_s;
            key_r       <= key_next_s;
            up_prev_r   <= btnUp;
            down_prev_r <= btnDown;
            rep_cnt_r   <= rep_cnt_next_s;
            rep_phase_r <= rep_phase_next_s;
            idle_cnt_r  <= idle_cnt_next_s;
            blink_cnt_r <= blink_cnt_next_s;
            blink_r     <= blink_next_s;
            cursor_r    <= cursor_of(mode_next_s);
            editing_r   <= (mode_next_s != MODE_RUN);
            up_r        <= up_next_s;
            down_r      <= down_next_s;
            clear_r     <= btnClear;
        end
    end

    assign cursorPos = cursor_r;
    assign editing   = editing_r;
    assign up        = up_r;
    assign down      = down_r;
    assign clearTime = clear_r;
    assign blinkOn   = blink_r;

endmodule
